// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide unit: MDU op encoding and
// default busy durations. Used by mult_div_unit (optional divider: MDU_DIV_EN).
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Width of a down-counter that must hold the larger of two cycle counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at acceptance into pending registers and committed
// when the busy down-counter reaches zero. The divider (DIV/DIVU) exists only
// when MDU_DIV_EN is defined; otherwise those ops behave like NONE.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;

  logic signed [63:0] w_rs_sx;
  logic signed [63:0] w_rt_sx;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;

  assign w_rs_sx  = {{32{rs_val[31]}}, rs_val};
  assign w_rt_sx  = {{32{rt_val[31]}}, rt_val};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

`ifdef MDU_DIV_EN
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quot_u;
  logic        [31:0] w_rem_u;
  logic               w_div_zero;

  assign w_div_zero = (rt_val == 32'd0);

  // Quotient/remainder; operators are only evaluated for a non-zero divisor.
  always_comb begin
    w_quot_s = '0;
    w_rem_s  = '0;
    w_quot_u = '0;
    w_rem_u  = '0;
    if (!w_div_zero) begin
      w_quot_s = $signed(rs_val) / $signed(rt_val);
      w_rem_s  = $signed(rs_val) % $signed(rt_val);
      w_quot_u = rs_val / rt_val;
      w_rem_u  = rs_val % rt_val;
    end
  end
`endif

  assign busy   = (r_count != '0);
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  // Busy countdown with commit on the falling edge of busy; accept new ops when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          r_count   <= CNT_W'(MULT_CYCLES);
          r_pend_hi <= w_prod_s[63:32];
          r_pend_lo <= w_prod_s[31:0];
        end
        OP_MULTU: begin
          r_count   <= CNT_W'(MULT_CYCLES);
          r_pend_hi <= w_prod_u[63:32];
          r_pend_lo <= w_prod_u[31:0];
        end
`ifdef MDU_DIV_EN
        OP_DIV: begin
          r_count <= CNT_W'(DIV_CYCLES);
          // A zero divisor re-commits the current HI/LO unchanged.
          if (w_div_zero) begin
            r_pend_hi <= r_hi;
            r_pend_lo <= r_lo;
          end else begin
            r_pend_hi <= w_rem_s;
            r_pend_lo <= w_quot_s;
          end
        end
        OP_DIVU: begin
          r_count <= CNT_W'(DIV_CYCLES);
          if (w_div_zero) begin
            r_pend_hi <= r_hi;
            r_pend_lo <= r_lo;
          end else begin
            r_pend_hi <= w_rem_u;
            r_pend_lo <= w_quot_u;
          end
        end
`endif
        OP_MTHI: r_hi <= rs_val;
        OP_MTLO: r_lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected
// {busy, hi, lo} tagged with the cycle they must appear; a monitor pops and
// compares on every falling clock edge.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    int          cyc;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input logic b, input logic [31:0] h,
                           input logic [31:0] l, input string n);
    exp_t e;
    e.cyc = c; e.busy = b; e.hi = h; e.lo = l; e.name = n;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
  endtask

  task automatic idle();
    start = 1'b0; op = OP_NONE; rs_val = '0; rt_val = '0;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", n, got, want, cyc);
    end
  endtask

  // Monitor: compare every entry due at the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          chk({e.name, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
          chk({e.name, ".hi"}, hi_out, e.hi);
          chk({e.name, ".lo"}, lo_out, e.lo);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int b, m, d, r, s, w;
    logic [31:0] eh, el;
    reset = 1'b0;
    idle();
    tick();
    tick();

    // Reset state, then MULT on first edge after release, ignored MTLO,
    // back-to-back MULTU held across the falling edge of busy.
    b = cyc;
    expect_at(b, 1'b0, 32'h0, 32'h0, "reset_state");
    reset = 1'b1;
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    expect_at(b + 1,  1'b1, 32'h0, 32'h0, "mult_e0");
    expect_at(b + 5,  1'b1, 32'h0, 32'h0, "mult_e4");
    expect_at(b + 6,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_done");
    expect_at(b + 7,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "multu_e0");
    expect_at(b + 11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "multu_hold");
    expect_at(b + 12, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, "multu_done");
    tick(); idle();
    tick(); drive(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
    tick(); idle();
    tick(); drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick(); tick(); tick(); idle();
    repeat (5) tick();

    // MTHI / MTLO / start with NONE.
    m = cyc;
    drive(OP_MTHI, 32'h1234_5678, 32'd0);
    expect_at(m + 1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFE, "mthi");
    tick();
    drive(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    expect_at(m + 2, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, "mtlo");
    tick();
    drive(OP_NONE, 32'd5, 32'd5);
    expect_at(m + 3, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, "op_none");
    tick(); idle();
    tick();

    d = cyc;
`ifdef MDU_DIV_EN
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    expect_at(d + 1,  1'b1, 32'h1234_5678, 32'hCAFE_F00D, "div_e0");
    expect_at(d + 10, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, "div_hold");
    expect_at(d + 11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_done");
    tick(); idle();
    repeat (10) tick();
    d = cyc;
    drive(OP_DIVU, 32'd100, 32'd0);
    expect_at(d + 1,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu0_e0");
    expect_at(d + 11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu0_done");
    tick(); idle();
    repeat (10) tick();
    d = cyc;
    drive(OP_DIVU, 32'd100, 32'd7);
    expect_at(d + 1,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_e0");
    expect_at(d + 11, 1'b0, 32'd2, 32'd14, "divu_done");
    tick(); idle();
    repeat (10) tick();
    eh = 32'd2; el = 32'd14;
`else
    drive(OP_DIV, 32'd8, 32'd2);
    expect_at(d + 1, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, "div_off");
    tick();
    drive(OP_DIVU, 32'd8, 32'd2);
    expect_at(d + 2, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, "divu_off");
    expect_at(d + 5, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, "div_off_later");
    tick(); idle();
    repeat (4) tick();
    eh = 32'h1234_5678; el = 32'hCAFE_F00D;
`endif

    // Asynchronous reset in the middle of a long operation.
    r = cyc;
`ifdef MDU_DIV_EN
    drive(OP_DIV, 32'd100, 32'd7);
`else
    drive(OP_MULT, 32'd3, 32'd5);
`endif
    expect_at(r + 2, 1'b1, eh, el, "pre_reset");
    tick(); idle();
    tick();
    tick();
    #1;
    reset = 1'b0;
    expect_at(r + 3, 1'b0, 32'h0, 32'h0, "reset_mid");
    tick();
    reset = 1'b1;
    expect_at(r + 4,  1'b0, 32'h0, 32'h0, "reset_release");
    expect_at(r + 14, 1'b0, 32'h0, 32'h0, "no_commit");
    repeat (10) tick();

    // Signed vs unsigned on all-ones operands.
    s = cyc;
    drive(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_at(s + 6, 1'b0, 32'h0, 32'h1, "mult_neg");
    tick(); idle();
    repeat (6) tick();
    s = cyc;
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_at(s + 6, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "multu_ones");
    tick(); idle();
    repeat (6) tick();

    w = 0;
    while (sb.size() > 0 && w < 50) begin
      tick();
      w++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
